// File: rtl/adr_bist.sv
// Exhaustive self-test sweep for a WIDTH-bit adder: drives every {x,cin,y} vector and
// compares {cout,sum} to x+y+cin. Optional ADR_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module adr_bist #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     x,
  output logic [WIDTH-1:0]     y,
  output logic                 cin,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_cnt,
  output logic                 fail_valid,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW  = 2*WIDTH + 1;
  localparam int CW  = 2*WIDTH + 2;
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    v_q, v_d;
  logic [STW-1:0]   settle_q, settle_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             cin_q, cin_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CW-1:0]    err_q, err_d;
  logic             fv_q, fv_d;
  logic [VW-1:0]    ff_q, ff_d;

  logic [WIDTH:0]   expected;
  logic             mismatch;
  logic             stop_now;

  // Operands come from the registered x/y/cin, which are exactly what the adder sees.
  assign expected = {1'b0, x_q} + {1'b0, y_q} + {{WIDTH{1'b0}}, cin_q};
  assign mismatch = ({cout, sum} != expected);

`ifdef ADR_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ff_d     = ff_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DRIVE;
          v_d      = '0;
          settle_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fv_d     = 1'b0;
          ff_d     = '0;
        end
      end
      DRIVE: begin
        if (settle_q == STW'(SETTLE - 1)) state_d = CHECK;
        else                              settle_d = settle_q + 1'b1;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = v_q;
          end
        end
        if (v_q == {VW{1'b1}} || stop_now) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = DRIVE;
          v_d      = v_q + 1'b1;
          settle_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Operands follow the next vector index so they change only at vector boundaries.
    y_d   = v_d[WIDTH-1:0];
    cin_d = v_d[WIDTH];
    x_d   = v_d[VW-1:WIDTH+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      v_q      <= '0;
      settle_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ff_q     <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      settle_q <= settle_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cin_q    <= cin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      ff_q     <= ff_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign cin        = cin_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_adr_bist.sv
// Bench for adr_bist: a faultable adder model beside the DUT, with expected results
// derived by enumerating all vectors arithmetically.
module tb_adr_bist;

  localparam int WIDTH  = 3;
  localparam int SETTLE = 1;
  localparam int NVEC   = 1 << (2*WIDTH + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [WIDTH-1:0]     x, y, sum;
  logic                 cin, cout;
  logic                 busy, done, pass, fail_valid;
  logic [2*WIDTH+1:0]   err_cnt;
  logic [2*WIDTH:0]     first_fail;

  int   fault = 0;
  logic bad [NVEC];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH:0] adder_r;

  adr_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x(x), .y(y), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .first_fail(first_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test, with selectable faults.
  always_comb begin
    adder_r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    case (fault)
      1: adder_r[WIDTH] = 1'b0;
      2: adder_r[0] = ~adder_r[0];
      3: if (bad[{x, cin, y}]) adder_r = adder_r ^ 1;
      default: ;
    endcase
    {cout, sum} = adder_r;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walk every vector, apply the fault rules, and report mismatch count and first index.
  task automatic ref_sweep(input int mode, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int v = 0; v < NVEC; v++) begin
      int xv, yv, cv, good, got;
      yv = v % (1 << WIDTH);
      cv = (v >> WIDTH) % 2;
      xv = v >> (WIDTH + 1);
      good = xv + yv + cv;
      got = good;
      if (mode == 1) got = good % (1 << WIDTH);
      if (mode == 2) got = good ^ 1;
      if (mode == 3 && bad[v]) got = good ^ 1;
      if (got != good) begin
        if (cnt == 0) first = v;
        cnt++;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_cin"}, 32'(cin), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"}, 32'(err_cnt), 0);
    chk({tag, "_fv"}, 32'(fail_valid), 0);
    chk({tag, "_ff"}, 32'(first_fail), 0);
  endtask

  // Pulse start, optionally pulse it again mid-sweep, and wait (bounded) for done.
  task automatic run_sweep(input string tag, input int mode, input int ignore_at);
    int p, busy_cycles, lat, cnt, first, exp_lat, exp_cnt;
    fault = mode;
    ref_sweep(mode, cnt, first);
`ifdef ADR_BIST_STOP_ON_FAIL_EN
    exp_cnt = (cnt > 0) ? 1 : 0;
    exp_lat = (cnt > 0) ? (first + 1) * (SETTLE + 1) + 1 : 1 + NVEC * (SETTLE + 1);
`else
    exp_cnt = cnt;
    exp_lat = 1 + NVEC * (SETTLE + 1);
`endif
    busy_cycles = 0;
    @(negedge clk);
    p = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && (cyc - p) < 3000) begin
      if (busy) busy_cycles++;
      if (mode == 0 && (cyc - p) == 37) begin
        chk({tag, "_mid_x"}, 32'(x), 1);
        chk({tag, "_mid_cin"}, 32'(cin), 0);
        chk({tag, "_mid_y"}, 32'(y), 2);
      end
      start = ((cyc - p) == ignore_at);
      @(negedge clk);
    end
    start = 1'b0;
    lat = cyc - p;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
    chk({tag, "_busy_low"}, 32'(busy), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    chk({tag, "_fail_valid"}, 32'(fail_valid), 32'(cnt > 0));
    chk({tag, "_first_fail"}, 32'(first_fail), 32'(first));
    chk({tag, "_pass"}, 32'(pass), 32'(cnt == 0));
    $display("sweep %s mode=%0d latency=%0d err_cnt=%0d first_fail=%0d pass=%0b",
             tag, mode, lat, err_cnt, first_fail, pass);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NVEC; i++) bad[i] = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("idle");

    run_sweep("good_ignore_start", 0, 10);
    run_sweep("cout_stuck0", 1, -1);
    run_sweep("sum0_inv", 2, -1);

    // Start from DONE with failures recorded: results must clear on the start edge.
    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_err_clear", 32'(err_cnt), 0);
    chk("restart_fv_clear", 32'(fail_valid), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_done_low", 32'(done), 0);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("restart_latency", 32'(n + 1), 32'(1 + NVEC * (SETTLE + 1)));
    chk("restart_pass", 32'(pass), 1);
    $display("restart from done latency=%0d pass=%0b", n + 1, pass);

    // Reset 50 cycles into a sweep, then a clean sweep.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    rst = 1'b0;
    $display("reset mid-sweep applied");
    run_sweep("after_rst", 0, -1);

    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < NVEC; i++) bad[i] = ($urandom_range(0, 5) == 0);
      run_sweep($sformatf("random%0d", it), 3, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
